vending_machine_param: RTL

- Parametrised successor to the single-price cola vending FSM.
- Accumulates coin credit in half-unit steps and pulses a vend output once credit reaches a configurable PRICE.
- Returns change serially, one pulse per half-unit, and supports a cancel/refund input.
- Has a mode that carries excess credit forward instead of refunding it; sits between coin-acceptor edge pulses and dispenser/return-hopper drivers.

---
 rtl/vm_pkg.sv | 13 +
 rtl/change_dispenser.sv | 49 ++++
 rtl/vending_machine_param.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared types and coin constants for the parametrised vending machine.
// Credit and change are counted in half-unit steps.
package vm_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        CHANGE = 1'b1
    } vm_state_e;

    localparam int COIN_HALF = 1;
    localparam int COIN_ONE  = 2;

endpackage

// File: rtl/change_dispenser.sv
// Loadable down-counter that emits one money pulse per half-unit of change.
// Pulses begin on the cycle after a load and run back-to-back until empty.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             money,
    output logic             empty
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             money_q;
    logic             money_d;

    // Next count and pulse: a load always wins over counting down.
    always_comb begin
        cnt_d   = cnt_q;
        money_d = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            money_d = 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= {CNT_W{1'b0}};
            money_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            money_q <= money_d;
        end
    end

    assign money = money_q;
    assign empty = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised vending FSM: accumulates half-unit credit, vends at PRICE,
// and hands change/refunds to the serial change dispenser.
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int PRICE     = 5,
    parameter int CREDIT_W  = 4,
    parameter int CHANGE_EN = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                pi_money_half,
    input  logic                pi_money_one,
    input  logic                pi_cancel,
    output logic                po_cola,
    output logic                po_money,
    output logic                po_busy,
    output logic                po_reject,
    output logic [CREDIT_W-1:0] po_credit
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] HALF_C  = CREDIT_W'(COIN_HALF);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(COIN_ONE);
    localparam logic [CREDIT_W-1:0] ZERO_C  = {CREDIT_W{1'b0}};

    vm_state_e           state_q;
    vm_state_e           state_d;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] credit_d;
    logic                cola_q;
    logic                cola_d;
    logic                busy_q;
    logic                busy_d;
    logic                reject_q;
    logic                reject_d;

    logic [CREDIT_W-1:0] add_s;
    logic [CREDIT_W-1:0] sum_s;
    logic [CREDIT_W-1:0] excess_s;
    logic                disp_load_s;
    logic [CREDIT_W-1:0] disp_val_s;
    logic                disp_money_s;
    logic                disp_empty_s;

    // Next-state, credit and pulse outputs; vend takes priority over cancel.
    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        cola_d      = 1'b0;
        reject_d    = 1'b0;
        disp_load_s = 1'b0;
        disp_val_s  = ZERO_C;
        add_s       = (pi_money_half ? HALF_C : ZERO_C) + (pi_money_one ? ONE_C : ZERO_C);
        sum_s       = credit_q + add_s;
        excess_s    = sum_s - PRICE_C;

        case (state_q)
            IDLE: begin
                if (sum_s >= PRICE_C) begin
                    cola_d = 1'b1;
                    if ((CHANGE_EN != 0) && (excess_s != ZERO_C)) begin
                        credit_d    = ZERO_C;
                        disp_load_s = 1'b1;
                        disp_val_s  = excess_s;
                        state_d     = CHANGE;
                    end else begin
                        credit_d = excess_s;
                    end
                end else if (pi_cancel && (sum_s != ZERO_C)) begin
                    credit_d    = ZERO_C;
                    disp_load_s = 1'b1;
                    disp_val_s  = sum_s;
                    state_d     = CHANGE;
                end else begin
                    credit_d = sum_s;
                end
            end
            CHANGE: begin
                // Coins bounce back mechanically while change is paid out.
                reject_d = pi_money_half | pi_money_one;
                if (disp_empty_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = CHANGE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = ZERO_C;
            end
        endcase

        busy_d = (state_d == CHANGE);
    end

    // State and registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            credit_q <= ZERO_C;
            cola_q   <= 1'b0;
            busy_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            cola_q   <= cola_d;
            busy_q   <= busy_d;
            reject_q <= reject_d;
        end
    end

    change_dispenser #(
        .CNT_W(CREDIT_W)
    ) u_change_dispenser (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .load    (disp_load_s),
        .load_val(disp_val_s),
        .money   (disp_money_s),
        .empty   (disp_empty_s)
    );

    assign po_cola   = cola_q;
    assign po_money  = disp_money_s;
    assign po_busy   = busy_q;
    assign po_reject = reject_q;
    assign po_credit = credit_q;

endmodule
